icap_wb_fifo: RTL and testbench
===============================

ICAP_WB_FIFO -- requirements
Module: icap_wb_fifo

Interface
REQ-001 SHALL have parameter DW, default 16, ICAP data width; legal 8, 16, 32.
REQ-002 SHALL have parameter AW, default 4, log2 write-FIFO depth (depth 2^AW).
REQ-003 SHALL have parameter RD_TIMEOUT, default 255, max cycles waiting for icap_busy low on reads.
REQ-004 clk  in  1  clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 cyc_i, stb_i, we_i  in  1 each  Wishbone classic slave strobes.
REQ-007 adr_i  in  1  0 = data port, 1 = control/status port.
REQ-008 dat_i  in  32  write data; bits [DW-1:0] used on data port.
REQ-009 dat_o  out  32  read data; unused upper bits zero.
REQ-010 ack_o  out  1  single-cycle acknowledge.
REQ-011 icap_ce_n, icap_write_n  out  1 each  active-low ICAP enable/write, registered.
REQ-012 icap_i  out  DW  data to ICAP; icap_o  in  DW  data from ICAP; icap_busy  in  1.
REQ-013 icap_clk_en  out  1  gate enable for the external inverted-clock buffer; equals ~icap_ce_n.

Function
REQ-014 Data-port write SHALL push dat_i[DW-1:0] into the FIFO and ack next cycle when not full; when full, ack SHALL stall until a slot frees (push on the ack cycle).
REQ-015 Drain FSM states IDLE, WR, RD, RD_WAIT, RD_DONE; IDLE->WR when FIFO non-empty and icap_busy low.
REQ-016 In WR each cycle with icap_busy low SHALL pop one word and drive icap_ce_n=0, icap_write_n=0, icap_i=word; busy high SHALL hold icap_ce_n=1 and the word; WR->IDLE when FIFO empty.
REQ-017 Data-port read SHALL wait in IDLE until FIFO empty (write ordering preserved), then IDLE->RD: one cycle icap_ce_n=0, icap_write_n=1.
REQ-018 RD->RD_WAIT; RD_WAIT samples icap_o on first cycle icap_busy low into dat_o[DW-1:0], ->RD_DONE; RD_DONE asserts ack_o one cycle ->IDLE.
REQ-019 RD_WAIT exceeding RD_TIMEOUT cycles SHALL return 32'hDEAD_0000 | level, set sticky status bit timeout, and ack.
REQ-020 Status read (adr_i=1) SHALL ack next cycle with dat_o = {timeout[31], full[30], empty[29], icap_busy[28], zeros, fifo_level[AW:0]}.
REQ-021 Control write (adr_i=1): bit0=1 flushes FIFO (level 0, queued words discarded, WR->IDLE next cycle), bit1=1 clears timeout; acks next cycle.
REQ-022 fifo_level SHALL count 0..2^AW; push and pop in the same cycle SHALL leave level unchanged; pointers wrap modulo 2^AW.
REQ-023 ack_o SHALL never assert without cyc_i & stb_i, nor twice for one transaction; dropped cyc_i mid-read SHALL abort to IDLE without ack.
REQ-024 icap_write_n SHALL only change while icap_ce_n=1.

Reset
REQ-025 On reset: FSM IDLE, FIFO empty, level 0, timeout 0, ack_o 0, dat_o 0, icap_ce_n 1, icap_write_n 1, icap_i 0, icap_clk_en 0.
REQ-026 Reset mid-transfer SHALL discard FIFO contents and any pending read without ack.

Configuration
REQ-027 Macro ICAP_BITSWAP_EN: when defined, bits SHALL be reversed within each byte on icap_i and on icap_o capture (ICAP bit-order convention); when undefined, data passes unswapped.

Verification
REQ-028 DW=16: write 16'hAA99, 16'h5566 -> two ICAP write cycles, icap_i AA99 then 5566, status level returns 0.
REQ-029 AW=2, icap_busy held high, 5 data writes -> 4 acked, 5th stalls; busy low -> 5th acks, all 5 words emitted in order.
REQ-030 Read with icap_busy high 3 cycles, icap_o=16'h1234 -> dat_o=32'h00001234, ack exactly once after busy falls.
REQ-031 RD_TIMEOUT=8, busy stuck high on read -> ack with 32'hDEAD0000, status bit31=1; control write 2 clears it.
REQ-032 ICAP_BITSWAP_EN defined, write 16'h0001 -> icap_i=16'h0080; undefined -> 16'h0001.
REQ-033 Three queued words then control write 1 -> no further ICAP writes, status shows empty=1, level 0.

Source files
------------

// File: rtl/icap_wb_fifo.sv
// icap_wb_fifo: Wishbone classic slave that buffers configuration words in a
// write FIFO and drains them into a Xilinx-style ICAP port. It also performs
// single-word ICAP readback with a busy timeout and exposes a control/status
// register at adr_i=1.
// Optional feature: define ICAP_BITSWAP_EN to reverse the bits within each byte
// on icap_i and when capturing icap_o.
module icap_wb_fifo #(
  parameter int DW         = 16,
  parameter int AW         = 4,
  parameter int RD_TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cyc_i,
  input  logic          stb_i,
  input  logic          we_i,
  input  logic          adr_i,
  input  logic [31:0]   dat_i,
  output logic [31:0]   dat_o,
  output logic          ack_o,
  output logic          icap_ce_n,
  output logic          icap_write_n,
  output logic [DW-1:0] icap_i,
  input  logic [DW-1:0] icap_o,
  input  logic          icap_busy,
  output logic          icap_clk_en
);

  localparam int DEPTH = 1 << AW;
  localparam int TW    = $clog2(RD_TIMEOUT + 2);
  localparam int PADW  = 28 - (AW + 1);

  typedef enum logic [2:0] {IDLE, WR, RD, RD_WAIT, RD_DONE} state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]     level_q, level_d;
  logic            timeout_q, timeout_d;
  logic            ack_q, ack_d;
  logic [31:0]     dat_o_q, dat_o_d;
  logic            ce_n_q, ce_n_d;
  logic            write_n_q, write_n_d;
  logic [DW-1:0]   icap_i_q, icap_i_d;
  logic [TW-1:0]   timer_q, timer_d;

  logic            req, data_wr_req, data_rd_req, ctl_wr, stat_rd;
  logic            push, pop, flush, full, empty;
  logic [31:0]     status;
  logic            unused_dat;

  // Reverse bits within each byte when the ICAP bit-order option is built in.
  function automatic logic [DW-1:0] bitswap(input logic [DW-1:0] w);
`ifdef ICAP_BITSWAP_EN
    logic [DW-1:0] r;
    for (int i = 0; i < DW; i++) r[i] = w[(i / 8) * 8 + 7 - (i % 8)];
    return r;
`else
    return w;
`endif
  endfunction

  // A new request is ignored during the ack cycle so one transaction acks once.
  assign req         = cyc_i & stb_i & ~ack_q;
  assign data_wr_req = req & we_i & ~adr_i;
  assign data_rd_req = req & ~we_i & ~adr_i;
  assign ctl_wr      = req & we_i & adr_i;
  assign stat_rd     = req & ~we_i & adr_i;
  assign flush       = ctl_wr & dat_i[0];
  assign full        = level_q[AW];
  assign empty       = (level_q == '0);
  assign status      = {timeout_q, full, empty, icap_busy, {PADW{1'b0}}, level_q};
  assign unused_dat  = ^dat_i;

  // Next-state logic for the drain/readback FSM, FIFO bookkeeping and bus replies.
  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    timeout_d = timeout_q;
    ack_d     = 1'b0;
    dat_o_d   = dat_o_q;
    ce_n_d    = ce_n_q;
    write_n_d = write_n_q;
    icap_i_d  = icap_i_q;
    timer_d   = timer_q;
    pop       = 1'b0;

    case (state_q)
      IDLE: begin
        ce_n_d    = 1'b1;
        write_n_d = 1'b1;
        if (!empty && !icap_busy && !flush) begin
          state_d   = WR;
          write_n_d = 1'b0;
        end else if (data_rd_req && empty) begin
          state_d = RD;
        end
      end
      WR: begin
        if (flush || empty) begin
          ce_n_d  = 1'b1;
          state_d = IDLE;
        end else if (!icap_busy) begin
          pop      = 1'b1;
          ce_n_d   = 1'b0;
          icap_i_d = bitswap(mem_q[rd_ptr_q]);
          rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
          ce_n_d = 1'b1;
        end
      end
      RD: begin
        if (!cyc_i) begin
          state_d = IDLE;
        end else begin
          ce_n_d  = 1'b0;
          timer_d = '0;
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        ce_n_d = 1'b1;
        if (!cyc_i) begin
          state_d = IDLE;
        end else if (!icap_busy) begin
          dat_o_d = 32'(bitswap(icap_o));
          ack_d   = stb_i;
          state_d = RD_DONE;
        end else if (timer_q == TW'(RD_TIMEOUT)) begin
          dat_o_d   = 32'hDEAD_0000 | 32'(level_q);
          timeout_d = 1'b1;
          ack_d     = stb_i;
          state_d   = RD_DONE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      RD_DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    push = data_wr_req & (~full | pop);
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      ack_d    = 1'b1;
    end
    if (push && !pop) level_d = level_q + (AW + 1)'(1);
    else if (pop && !push) level_d = level_q - (AW + 1)'(1);

    if (ctl_wr) begin
      ack_d = 1'b1;
      if (dat_i[1]) timeout_d = 1'b0;
    end
    if (flush) begin
      level_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
    if (stat_rd) begin
      ack_d   = 1'b1;
      dat_o_d = status;
    end
  end

  // FIFO storage; contents are only meaningful between the read and write pointers.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= dat_i[DW-1:0];
  end

  // State and registered outputs, cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      timeout_q <= 1'b0;
      ack_q     <= 1'b0;
      dat_o_q   <= '0;
      ce_n_q    <= 1'b1;
      write_n_q <= 1'b1;
      icap_i_q  <= '0;
      timer_q   <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      timeout_q <= timeout_d;
      ack_q     <= ack_d;
      dat_o_q   <= dat_o_d;
      ce_n_q    <= ce_n_d;
      write_n_q <= write_n_d;
      icap_i_q  <= icap_i_d;
      timer_q   <= timer_d;
    end
  end

  assign ack_o        = ack_q & cyc_i & stb_i;
  assign dat_o        = dat_o_q;
  assign icap_ce_n    = ce_n_q;
  assign icap_write_n = write_n_q;
  assign icap_i       = icap_i_q;
  assign icap_clk_en  = ~ce_n_q;

endmodule

// File: tb/tb_icap_wb_fifo.sv
// Testbench for icap_wb_fifo (DW=16, AW=2, RD_TIMEOUT=8). Stimulus queues the
// expected ICAP words and read data; a negedge monitor compares them as the
// DUT produces ICAP write cycles and read acknowledges.
module tb_icap_wb_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic        cyc_i, stb_i, we_i, adr_i;
  logic [31:0] dat_i;
  logic [31:0] dat_o;
  logic        ack_o;
  logic        icap_ce_n, icap_write_n;
  logic [15:0] icap_i;
  logic [15:0] icap_o;
  logic        icap_busy;
  logic        icap_clk_en;

  int checks_total  = 0;
  int checks_passed = 0;
  int ack_cnt       = 0;
  int rd_strobes    = 0;
  int wn_violations = 0;
  int clk_en_errors = 0;

  logic [15:0] exp_icap[$];
  logic [31:0] exp_rd[$];

`ifdef ICAP_BITSWAP_EN
  localparam logic [15:0] E_AA99 = 16'h5599, E_5566 = 16'hAA66, E_0001 = 16'h0080;
  localparam logic [15:0] E_1111 = 16'h8888, E_2222 = 16'h4444, E_3333 = 16'hCCCC;
  localparam logic [15:0] E_4444 = 16'h2222, E_5555 = 16'hAAAA;
  localparam logic [31:0] E_RD   = 32'h0000_482C;
`else
  localparam logic [15:0] E_AA99 = 16'hAA99, E_5566 = 16'h5566, E_0001 = 16'h0001;
  localparam logic [15:0] E_1111 = 16'h1111, E_2222 = 16'h2222, E_3333 = 16'h3333;
  localparam logic [15:0] E_4444 = 16'h4444, E_5555 = 16'h5555;
  localparam logic [31:0] E_RD   = 32'h0000_1234;
`endif

  icap_wb_fifo #(.DW(16), .AW(2), .RD_TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i),
    .adr_i(adr_i), .dat_i(dat_i), .dat_o(dat_o), .ack_o(ack_o),
    .icap_ce_n(icap_ce_n), .icap_write_n(icap_write_n), .icap_i(icap_i),
    .icap_o(icap_o), .icap_busy(icap_busy), .icap_clk_en(icap_clk_en)
  );

  always #5 clk = ~clk;

  // Compare one value against its required value and keep the tallies.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks_total++;
    if (actual === expected) checks_passed++;
    else $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
  endtask

  // One Wishbone classic transaction with a bounded wait for ack.
  task automatic applyStimulus(input string name, input logic adr, input logic we,
                               input logic [31:0] data, input logic [31:0] exp,
                               input int budget, output int waited);
    logic acked;
    if (!we) exp_rd.push_back(exp);
    @(posedge clk); #1;
    cyc_i = 1'b1; stb_i = 1'b1; we_i = we; adr_i = adr; dat_i = data;
    acked = 1'b0;
    waited = 0;
    while (!acked && waited < budget) begin
      @(negedge clk);
      waited++;
      if (ack_o) acked = 1'b1;
    end
    @(posedge clk); #1;
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; adr_i = 1'b0; dat_i = '0;
    if (!acked && !we) void'(exp_rd.pop_back());
    checkOutput({name, "_ack"}, {31'b0, acked}, 32'd1);
  endtask

  // Monitor: ICAP write words, read data on ack, and ICAP strobe rules.
  logic prev_ce_n = 1'b1, prev_wn = 1'b1;
  always @(negedge clk) begin
    if (!reset) begin
      if (!icap_ce_n && !icap_write_n) begin
        if (exp_icap.size() == 0) begin
          checks_total++;
          $display("[TB] FAIL icap_unexpected_write: got %h, required no write", icap_i);
        end else begin
          checkOutput("icap_word", {16'b0, icap_i}, {16'b0, exp_icap.pop_front()});
        end
      end
      if (!icap_ce_n && icap_write_n) rd_strobes++;
      if (ack_o) begin
        ack_cnt++;
        if (!we_i) begin
          if (exp_rd.size() == 0) begin
            checks_total++;
            $display("[TB] FAIL read_unexpected_ack: got %h, required no ack", dat_o);
          end else begin
            checkOutput("read_data", dat_o, exp_rd.pop_front());
          end
        end
      end
      if (icap_write_n != prev_wn && (!icap_ce_n || !prev_ce_n)) wn_violations++;
      if (icap_clk_en != ~icap_ce_n) clk_en_errors++;
    end
    prev_ce_n = icap_ce_n;
    prev_wn   = icap_write_n;
  end

  // Watchdog so the bench can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  int w, w5, acks_before, strobes_before;

  initial begin
    reset = 1'b1; cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; adr_i = 1'b0;
    dat_i = '0; icap_o = '0; icap_busy = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_ack", {31'b0, ack_o}, 32'd0);
    checkOutput("rst_dat", dat_o, 32'd0);
    checkOutput("rst_ce_n", {31'b0, icap_ce_n}, 32'd1);
    checkOutput("rst_write_n", {31'b0, icap_write_n}, 32'd1);
    checkOutput("rst_icap_i", {16'b0, icap_i}, 32'd0);
    checkOutput("rst_clk_en", {31'b0, icap_clk_en}, 32'd0);
    @(posedge clk); #1 reset = 1'b0;

    $display("[TB] status after reset");
    applyStimulus("st_reset", 1'b1, 1'b0, 32'd0, 32'h2000_0000, 10, w);

    $display("[TB] two-word write drain");
    exp_icap.push_back(E_AA99);
    applyStimulus("wr_aa99", 1'b0, 1'b1, 32'h0000_AA99, 32'd0, 10, w);
    exp_icap.push_back(E_5566);
    applyStimulus("wr_5566", 1'b0, 1'b1, 32'hFFFF_5566, 32'd0, 10, w);
    repeat (10) @(posedge clk);
    applyStimulus("st_drained", 1'b1, 1'b0, 32'd0, 32'h2000_0000, 10, w);

    $display("[TB] bit order");
    exp_icap.push_back(E_0001);
    applyStimulus("wr_0001", 1'b0, 1'b1, 32'h0000_0001, 32'd0, 10, w);
    repeat (10) @(posedge clk);

    $display("[TB] full FIFO stall");
    icap_busy = 1'b1;
    exp_icap.push_back(E_1111); exp_icap.push_back(E_2222); exp_icap.push_back(E_3333);
    exp_icap.push_back(E_4444); exp_icap.push_back(E_5555);
    applyStimulus("wr_1111", 1'b0, 1'b1, 32'h0000_1111, 32'd0, 10, w);
    applyStimulus("wr_2222", 1'b0, 1'b1, 32'h0000_2222, 32'd0, 10, w);
    applyStimulus("wr_3333", 1'b0, 1'b1, 32'h0000_3333, 32'd0, 10, w);
    applyStimulus("wr_4444", 1'b0, 1'b1, 32'h0000_4444, 32'd0, 10, w);
    applyStimulus("st_full", 1'b1, 1'b0, 32'd0, 32'h5000_0004, 10, w);
    fork
      applyStimulus("wr_5555", 1'b0, 1'b1, 32'h0000_5555, 32'd0, 40, w5);
      begin
        repeat (10) @(negedge clk);
        icap_busy = 1'b0;
      end
    join
    checkOutput("stall_5th", {31'b0, (w5 >= 10)}, 32'd1);
    repeat (20) @(posedge clk);
    applyStimulus("st_after_stall", 1'b1, 1'b0, 32'd0, 32'h2000_0000, 10, w);

    $display("[TB] readback with busy");
    icap_o = 16'h1234;
    icap_busy = 1'b1;
    acks_before = ack_cnt;
    strobes_before = rd_strobes;
    fork
      applyStimulus("rd_1234", 1'b0, 1'b0, 32'd0, E_RD, 30, w);
      begin
        repeat (5) @(negedge clk);
        icap_busy = 1'b0;
      end
    join
    repeat (5) @(posedge clk);
    checkOutput("rd_ack_once", 32'(ack_cnt - acks_before), 32'd1);
    checkOutput("rd_strobe_once", 32'(rd_strobes - strobes_before), 32'd1);

    $display("[TB] readback timeout");
    icap_busy = 1'b1;
    applyStimulus("rd_timeout", 1'b0, 1'b0, 32'd0, 32'hDEAD_0000, 40, w);
    applyStimulus("st_timeout", 1'b1, 1'b0, 32'd0, 32'hB000_0000, 10, w);
    applyStimulus("ctl_clear", 1'b1, 1'b1, 32'd2, 32'd0, 10, w);
    applyStimulus("st_cleared", 1'b1, 1'b0, 32'd0, 32'h3000_0000, 10, w);
    icap_busy = 1'b0;

    $display("[TB] flush");
    icap_busy = 1'b1;
    applyStimulus("wr_q0", 1'b0, 1'b1, 32'h0000_CAFE, 32'd0, 10, w);
    applyStimulus("wr_q1", 1'b0, 1'b1, 32'h0000_BEEF, 32'd0, 10, w);
    applyStimulus("wr_q2", 1'b0, 1'b1, 32'h0000_F00D, 32'd0, 10, w);
    applyStimulus("st_level3", 1'b1, 1'b0, 32'd0, 32'h1000_0003, 10, w);
    applyStimulus("ctl_flush", 1'b1, 1'b1, 32'd1, 32'd0, 10, w);
    applyStimulus("st_flushed", 1'b1, 1'b0, 32'd0, 32'h3000_0000, 10, w);
    icap_busy = 1'b0;
    repeat (10) @(posedge clk);
    applyStimulus("st_flush_idle", 1'b1, 1'b0, 32'd0, 32'h2000_0000, 10, w);

    $display("[TB] reset mid-transfer");
    icap_busy = 1'b1;
    applyStimulus("wr_r0", 1'b0, 1'b1, 32'h0000_0F0F, 32'd0, 10, w);
    applyStimulus("wr_r1", 1'b0, 1'b1, 32'h0000_F0F0, 32'd0, 10, w);
    @(posedge clk); #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    icap_busy = 1'b0;
    repeat (10) @(posedge clk);
    applyStimulus("st_after_reset", 1'b1, 1'b0, 32'd0, 32'h2000_0000, 10, w);

    repeat (3) @(posedge clk);
    checkOutput("icap_queue_drained", 32'(exp_icap.size()), 32'd0);
    checkOutput("read_queue_drained", 32'(exp_rd.size()), 32'd0);
    checkOutput("write_n_only_with_ce_high", 32'(wn_violations), 32'd0);
    checkOutput("clk_en_tracks_ce", 32'(clk_en_errors), 32'd0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
